dlx_mmio: RTL and testbench

//  Memory-mapped I/O responder on the DLX data bus; the target end of the d_* interface, alongside the data RAM.

---
 rtl/dlx_mmio_if.sv | 23 ++
 rtl/dlx_mmio.sv | 148 ++++++++++++++
 tb/tb_dlx_mmio.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dlx_mmio_if.sv
// dlx_mmio_if: DLX data-bus slice seen by the memory-mapped I/O responder.
//   addr        byte address from the core (addr[1:0] ignored by the target)
//   we          write enable; the target qualifies it with its own sel
//   wdata       write data
//   sel         target's combinational decode of addr into its window
//   rdata       registered read data; holds its last value between reads
//   rdata_valid registered strobe
// Transfer semantics: there is no ready/stall. Every cycle in which sel=1 is
// one complete access. A read (we=0) presented in cycle N is answered in cycle
// N+1 with rdata_valid=1 for exactly one cycle. A write (we=1) takes effect at
// the edge that ends cycle N and never raises rdata_valid. Accesses may be
// issued back-to-back on every cycle.
interface dlx_mmio_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        sel;
  logic [31:0] rdata;
  logic        rdata_valid;

  modport master (output addr, we, wdata, input sel, rdata, rdata_valid);
  modport slave  (input addr, we, wdata, output sel, rdata, rdata_valid);
endinterface

// File: rtl/dlx_mmio.sv
// dlx_mmio: memory-mapped board I/O responder on the DLX data bus.
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   bus (slave)       addr/we/wdata in, sel/rdata/rdata_valid out
//   sw[9:0]           asynchronous switches
//   key[3:0]          asynchronous keys, active-low (0 = pressed)
//   ledr[9:0]         LED drive
//   hex0..hex5[6:0]   seven-segment digits, active-low {g,f,e,d,c,b,a}
// Register map (offset = addr[5:2]*4): 0x00 LEDR, 0x04 HEX (digits + blank
// mask), 0x08 SW, 0x0C KEY, 0x10 KEYEV (W1C), 0x14 TIMER (write clears).
module dlx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  dlx_mmio_if.slave   bus,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [9:0]  ledr,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [3:0] OFF_LEDR  = 4'd0;
  localparam logic [3:0] OFF_HEX   = 4'd1;
  localparam logic [3:0] OFF_SW    = 4'd2;
  localparam logic [3:0] OFF_KEY   = 4'd3;
  localparam logic [3:0] OFF_KEYEV = 4'd4;
  localparam logic [3:0] OFF_TIMER = 4'd5;

  logic [3:0]  idx;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_mux;

  logic [9:0]  sw_sync  [SYNC_STAGES];
  logic [3:0]  key_sync [SYNC_STAGES];
  logic [3:0]  pressed;
  logic [3:0]  pressed_q;
  logic [3:0]  press_edge;
  logic [3:0]  keyev_clr;

  logic [9:0]  ledr_q;
  logic [29:0] hex_reg;     // [23:0] digits, [29:24] blank mask
  logic [3:0]  keyev;
  logic [31:0] timer;
  logic [6:0]  hex_q [6];

  // Byte lane and the top wdata bits carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:30]};

  assign idx     = bus.addr[5:2];
  assign bus.sel = (bus.addr[31:6] == BASE_ADDR[31:6]);
  assign wr_en   = bus.sel & bus.we;
  assign rd_en   = bus.sel & ~bus.we;

  // Keys are inverted before synchronising so the whole chain resets to
  // "not pressed" and no false press edge appears on reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= '0;
        key_sync[i] <= '0;
      end
    end else begin
      sw_sync[0]  <= sw;
      key_sync[0] <= ~key;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i]  <= sw_sync[i-1];
        key_sync[i] <= key_sync[i-1];
      end
    end
  end

  assign pressed    = key_sync[SYNC_STAGES-1];
  assign press_edge = pressed & ~pressed_q;
  assign keyev_clr  = (wr_en && idx == OFF_KEYEV) ? bus.wdata[3:0] : 4'h0;

  always_comb begin
    rd_mux = 32'h0;
    case (idx)
      OFF_LEDR:  rd_mux = {22'h0, ledr_q};
      OFF_HEX:   rd_mux = {2'b00, hex_reg};
      OFF_SW:    rd_mux = {22'h0, sw_sync[SYNC_STAGES-1]};
      OFF_KEY:   rd_mux = {28'h0, pressed};
      OFF_KEYEV: rd_mux = {28'h0, keyev};
      OFF_TIMER: rd_mux = timer;
      default:   rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr_q          <= '0;
      hex_reg         <= {6'h3F, 24'h0};
      keyev           <= '0;
      timer           <= '0;
      pressed_q       <= '0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      pressed_q <= pressed;
      if (wr_en && idx == OFF_LEDR) ledr_q  <= bus.wdata[9:0];
      if (wr_en && idx == OFF_HEX)  hex_reg <= bus.wdata[29:0];
      // Set is OR-ed after the clear so a coincident press survives a W1C.
      keyev <= (keyev & ~keyev_clr) | press_edge;
      // Write-to-clear beats the increment on the same edge.
      timer <= (wr_en && idx == OFF_TIMER) ? 32'h0 : timer + 32'h1;
      bus.rdata_valid <= rd_en;
      if (rd_en) bus.rdata <= rd_mux;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 6; n++) hex_q[n] <= 7'h7F;
    end else begin
      for (int n = 0; n < 6; n++)
        hex_q[n] <= hex_reg[24+n] ? 7'h7F : seg7(hex_reg[4*n +: 4]);
    end
  end

  assign ledr = ledr_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_dlx_mmio.sv
module tb_dlx_mmio;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          SYNC = 2;

  // Active-high {g,f,e,d,c,b,a} glyphs for 0..F; the board drives them inverted.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0] hex_o [6];

  assign hex_o[0] = hex0;
  assign hex_o[1] = hex1;
  assign hex_o[2] = hex2;
  assign hex_o[3] = hex3;
  assign hex_o[4] = hex4;
  assign hex_o[5] = hex5;

  dlx_mmio_if bus ();

  dlx_mmio #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .sw(sw), .key(key), .ledr(ledr),
    .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .hex3(hex3), .hex4(hex4), .hex5(hex5));

  // Edges since reset release; the timer model is built on this.
  int edge_cnt;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;

  // ---------------- reference model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [9:0]  m_ledr;
  logic [29:0] m_hex;
  logic [3:0]  m_keyev;
  int          m_zero_edge;
  logic [31:0] m_last_rdata;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_digit(input int n);
    logic [3:0] nib;
    nib = m_hex[4*n +: 4];
    return m_hex[24+n] ? 7'h7F : ~GLYPH[nib];
  endfunction

  task automatic chk_display(input string tag);
    for (int n = 0; n < 6; n++) chk($sformatf("%s_hex%0d", tag, n), {25'h0, hex_o[n]}, {25'h0, exp_digit(n)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.addr = 32'h0; bus.we = 1'b0; bus.wdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [5:0] off, input logic [31:0] data);
    bus.addr = BASE | {26'h0, off}; bus.we = 1'b1; bus.wdata = data;
    @(posedge clk); #1;
    chk("wr_no_valid", {31'h0, bus.rdata_valid}, 32'h0);
    bus.we = 1'b0; bus.addr = 32'h0;
  endtask

  task automatic do_read(input string tag, input logic [5:0] off);
    logic [31:0] exp;
    bus.addr = BASE | {26'h0, off}; bus.we = 1'b0;
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    chk({tag, "_valid"}, {31'h0, bus.rdata_valid}, 32'h1);
    chk(tag, bus.rdata, exp);
    m_last_rdata = exp;
    bus.addr = 32'h0;
  endtask

  task automatic rd_timer(input string tag);
    // Value seen at the next edge = edges elapsed since the timer was zeroed.
    exp_q.push_back(32'(edge_cnt - m_zero_edge));
    do_read(tag, 6'h14);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    bus.addr = 32'h0; bus.we = 1'b0; bus.wdata = 32'h0;
    sw = 10'h0; key = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    m_ledr = 10'h0; m_hex = {6'h3F, 24'h0}; m_keyev = 4'h0; m_zero_edge = 0; m_last_rdata = 32'h0;

    // Reset state
    chk("rst_ledr", {22'h0, ledr}, 32'h0);
    chk("rst_valid", {31'h0, bus.rdata_valid}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk_display("rst");
    rd_timer("rst_timer");
    exp_q.push_back({2'b0, m_hex}); do_read("rst_hexreg", 6'h04);

    // HEX write and display
    do_write(6'h04, 32'h0012_3456); m_hex = 30'h0012_3456;
    exp_q.push_back(32'h0012_3456); do_read("hex_rd", 6'h04);
    chk_display("hex123456");

    // sel decode and non-selected accesses
    bus.addr = 32'h0000_1000; bus.we = 1'b0; #1;
    chk("sel_out", {31'h0, bus.sel}, 32'h0);
    @(posedge clk); #1;
    chk("nosel_valid", {31'h0, bus.rdata_valid}, 32'h0);
    chk("nosel_hold", bus.rdata, m_last_rdata);
    bus.addr = BASE | 32'h3C; #1;
    chk("sel_in", {31'h0, bus.sel}, 32'h1);
    bus.addr = 32'hFFFE_0000; bus.we = 1'b1; bus.wdata = 32'h3FF;
    @(posedge clk); #1;
    bus.we = 1'b0;
    chk("nosel_wr", {22'h0, ledr}, {22'h0, m_ledr});

    // Unmapped offset: reads 0, writes ignored
    do_write(6'h3C, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0); do_read("unmapped", 6'h3C);
    exp_q.push_back({22'h0, m_ledr}); do_read("unmapped_wr_ledr", 6'h00);

    // Randomized LEDR / HEX / SW traffic against the model
    for (int it = 0; it < 12; it++) begin
      d = $urandom;
      do_write(6'h00, d); m_ledr = d[9:0];
      chk("rnd_ledr_pin", {22'h0, ledr}, {22'h0, m_ledr});
      exp_q.push_back({22'h0, m_ledr}); do_read("rnd_ledr_rd", 6'h00);
      d = $urandom;
      d[29:24] = 6'($urandom_range(0, 63) & (it[0] ? 6'h3F : 6'h15));
      do_write(6'h04, d); m_hex = d[29:0];
      exp_q.push_back({2'b0, m_hex}); do_read("rnd_hex_rd", 6'h04);
      chk_display("rnd");
      sw = 10'($urandom_range(0, 1023));
      repeat (SYNC) idle();
      exp_q.push_back({22'h0, sw}); do_read("rnd_sw", 6'h08);
    end
    sw = 10'h2A5;
    repeat (SYNC) idle();
    exp_q.push_back(32'h0000_02A5); do_read("sw_2a5", 6'h08);

    // Keys: press key[2] for 5 cycles
    key = 4'b1011;
    repeat (SYNC) idle();
    exp_q.push_back(32'h4); do_read("key_pressed", 6'h0C);
    repeat (2) idle();
    key = 4'hF; m_keyev = 4'h4;
    repeat (SYNC + 2) idle();
    exp_q.push_back({28'h0, m_keyev}); do_read("keyev_set", 6'h10);
    exp_q.push_back(32'h0); do_read("key_released", 6'h0C);
    do_write(6'h10, 32'h4); m_keyev = 4'h0;
    exp_q.push_back({28'h0, m_keyev}); do_read("keyev_w1c", 6'h10);
    key = 4'b1011; repeat (5) idle(); key = 4'hF; m_keyev = 4'h4;
    repeat (SYNC + 2) idle();
    exp_q.push_back({28'h0, m_keyev}); do_read("keyev_reset2", 6'h10);
    // New press edge lands on the same edge as the W1C: the flag stays set.
    key = 4'b1011;
    repeat (SYNC) idle();
    do_write(6'h10, 32'h4);
    exp_q.push_back(32'h4); do_read("keyev_coincident", 6'h10);
    key = 4'hF;
    repeat (SYNC + 2) idle();
    do_write(6'h10, 32'hF); m_keyev = 4'h0;
    exp_q.push_back(32'h0); do_read("keyev_clr_all", 6'h10);

    // Timer: free-running, write clears, write beats increment
    rd_timer("timer_run");
    do_write(6'h14, 32'hDEAD_BEEF); m_zero_edge = edge_cnt;
    exp_q.push_back(32'h0); do_read("timer_zero", 6'h14);
    repeat (3) idle();
    rd_timer("timer_after");

    // Back-to-back write then read, then reset in the middle of a read
    bus.addr = BASE; bus.we = 1'b1; bus.wdata = 32'h0000_03FF;
    @(posedge clk); #1; m_ledr = 10'h3FF;
    bus.we = 1'b0;
    chk("b2b_ledr_pin", {22'h0, ledr}, 32'h3FF);
    @(posedge clk); #1;
    chk("b2b_valid", {31'h0, bus.rdata_valid}, 32'h1);
    chk("b2b_rd", bus.rdata, 32'h0000_03FF);
    reset_n = 1'b0; #1;
    chk("midrst_valid", {31'h0, bus.rdata_valid}, 32'h0);
    chk("midrst_ledr", {22'h0, ledr}, 32'h0);
    m_hex = {6'h3F, 24'h0};
    chk_display("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
